// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result path.
package calc_pkg;

  // Result formatting mode; the encoding 2'b11 is handled as hex.
  typedef enum logic [1:0] {
    FMT_HEX  = 2'b00,
    FMT_UDEC = 2'b01,
    FMT_SDEC = 2'b10
  } fmt_e;

  // ASCII characters the encoder emits.
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // Line formatter states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_SEND,
    ST_EOL
  } enc_state_e;

  // Uppercase ASCII for one hex nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return CH_0 + {4'h0, nib};
    end
    return CH_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with registered read port. Pointers carry one extra
// wrap bit so full and empty are told apart by the MSB comparison.
module result_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = rd_data_reg;

  // Storage array: written on accepted push, no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // Registered read: the popped entry is presented the cycle after the pop.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/result_line_encoder.sv
// Buffers ALU results and streams each one to the UART as an ASCII line
// (hex, unsigned or signed decimal) terminated by CR/LF or LF.
module result_line_encoder
  import calc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit EOL_CRLF   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic [1:0]        res_fmt,
  output logic              res_ready,
  output logic              overflow,
  output logic [7:0]        uart_out,
  output logic              uout_valid,
  input  logic              uin_ready,
  output logic              busy
);

  localparam int DEC_DIGITS = (DATA_W * 77) / 256 + 1;
  localparam int HEX_DIGITS = DATA_W / 4;
  localparam int DIG_W      = $clog2(DEC_DIGITS + 1);
  localparam int HEX_W      = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;
  localparam int BIT_W      = $clog2(DATA_W);

  enc_state_e state_reg, state_next;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W+1:0] fifo_rd;
  logic [1:0]        ld_fmt;
  logic [DATA_W-1:0] ld_data;
  logic              ld_neg;
  logic              ld_dec;

  logic [DATA_W-1:0] value_reg;
  logic              dec_reg;
  logic              sign_pend_reg;
  logic              cr_pend_reg;
  logic [3:0]        rem_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [DIG_W-1:0]  dig_cnt_reg;
  logic [HEX_W-1:0]  hex_idx_reg;
  logic [3:0]        dig_slot [DEC_DIGITS];
  logic [3:0]        dig_top;

  logic [4:0]        div_trial;
  logic [4:0]        div_sub;
  logic              div_ge;
  logic [3:0]        div_rem;
  logic [DATA_W-1:0] div_quot;
  logic              last_bit;
  logic              digit_done;
  logic              xfer;
  logic [7:0]        send_byte;

  // Result FIFO: {fmt, data} per entry.
  result_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data ({res_fmt, res_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign res_ready = !fifo_full;
  assign overflow  = res_valid && fifo_full;
  assign fifo_push = res_valid && res_ready;
  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;
  assign xfer      = uout_valid && uin_ready;

  assign ld_fmt  = fifo_rd[DATA_W+1:DATA_W];
  assign ld_data = fifo_rd[DATA_W-1:0];
  assign ld_dec  = (ld_fmt == FMT_UDEC) || (ld_fmt == FMT_SDEC);
  assign ld_neg  = (ld_fmt == FMT_SDEC) && ld_data[DATA_W-1];

  // Restoring divide-by-10 step: the dividend shifts out of value_reg's MSB
  // while quotient bits shift in at the LSB.
  assign div_trial  = {rem_reg, value_reg[DATA_W-1]};
  assign div_sub    = div_trial - 5'd10;
  assign div_ge     = (div_trial >= 5'd10);
  assign div_rem    = div_ge ? div_sub[3:0] : div_trial[3:0];
  assign div_quot   = {value_reg[DATA_W-2:0], div_ge};
  assign last_bit   = (bit_cnt_reg == BIT_W'(DATA_W - 1));
  assign digit_done = (state_reg == ST_CONV) && last_bit;

  // Digit stack slots: each slot captures the remainder produced when it is
  // the next free position.
  for (genvar gi = 0; gi < DEC_DIGITS; gi++) begin : g_dig
    always_ff @(posedge clk) begin
      if (digit_done && (dig_cnt_reg == DIG_W'(gi))) begin
        dig_slot[gi] <= div_rem;
      end
    end
  end

  // Top of the digit stack (most significant remaining digit).
  always_comb begin
    dig_top = 4'h0;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (DIG_W'(i) == dig_cnt_reg - 1'b1) dig_top = dig_slot[i];
    end
  end

  // Character currently offered in SEND.
  always_comb begin
    send_byte = CH_0 + {4'h0, dig_top};
    if (sign_pend_reg) begin
      send_byte = CH_MINUS;
    end else if (!dec_reg) begin
      send_byte = hex_char(value_reg[DATA_W-1 -: 4]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and the UART-side outputs.
  always_comb begin
    state_next = state_reg;
    uout_valid = 1'b0;
    uart_out   = 8'h00;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next = ld_dec ? ST_CONV : ST_SEND;
      end
      ST_CONV: begin
        if (last_bit && (div_quot == '0)) state_next = ST_SEND;
      end
      ST_SEND: begin
        uout_valid = 1'b1;
        uart_out   = send_byte;
        if (uin_ready && !sign_pend_reg &&
            ((!dec_reg && hex_idx_reg == '0) ||
             (dec_reg && dig_cnt_reg == DIG_W'(1)))) begin
          state_next = ST_EOL;
        end
      end
      ST_EOL: begin
        uout_valid = 1'b1;
        uart_out   = cr_pend_reg ? CH_CR : CH_LF;
        if (uin_ready && !cr_pend_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line datapath: operand load, digit generation and per-byte bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg     <= '0;
      dec_reg       <= 1'b0;
      sign_pend_reg <= 1'b0;
      cr_pend_reg   <= 1'b0;
      rem_reg       <= '0;
      bit_cnt_reg   <= '0;
      dig_cnt_reg   <= '0;
      hex_idx_reg   <= '0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          value_reg     <= ld_neg ? (-ld_data) : ld_data;
          dec_reg       <= ld_dec;
          sign_pend_reg <= ld_neg;
          cr_pend_reg   <= EOL_CRLF;
          rem_reg       <= '0;
          bit_cnt_reg   <= '0;
          dig_cnt_reg   <= '0;
          hex_idx_reg   <= HEX_W'(HEX_DIGITS - 1);
        end
        ST_CONV: begin
          value_reg <= div_quot;
          if (last_bit) begin
            rem_reg     <= '0;
            bit_cnt_reg <= '0;
            dig_cnt_reg <= dig_cnt_reg + 1'b1;
          end else begin
            rem_reg     <= div_rem;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (sign_pend_reg) begin
              sign_pend_reg <= 1'b0;
            end else if (!dec_reg) begin
              value_reg   <= {value_reg[DATA_W-5:0], 4'h0};
              hex_idx_reg <= hex_idx_reg - 1'b1;
            end else begin
              dig_cnt_reg <= dig_cnt_reg - 1'b1;
            end
          end
        end
        ST_EOL: begin
          if (xfer) cr_pend_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_line_encoder.sv
// Bench for result_line_encoder: transaction-level reference model with a
// per-cycle compare, plus directed cases with literal expected lines.
module tb_result_line_encoder;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_fmt;
  logic        uin_ready;
  logic        res_ready;
  logic        overflow;
  logic [7:0]  uart_out;
  logic        uout_valid;
  logic        busy;

  always #5 clk = ~clk;

  result_line_encoder #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .EOL_CRLF   (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_fmt    (res_fmt),
    .res_ready  (res_ready),
    .overflow   (overflow),
    .uart_out   (uart_out),
    .uout_valid (uout_valid),
    .uin_ready  (uin_ready),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending results, current line bytes, wait cycles
  // before the first byte of the line appears.
  logic [17:0] m_fifo[$];
  byte         m_line[$];
  bit          m_active = 0;
  int          m_wait = 0;
  byte         rx_q[$];
  bit          stall_prev = 0;
  logic [7:0]  stall_byte = 8'h00;
  bit          rnd_ready = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Text of one result line (without EOL) from the formatting rules.
  function automatic string line_text(input logic [15:0] d, input logic [1:0] f);
    string hexd;
    string s;
    int    v;
    hexd = "0123456789ABCDEF";
    s = "";
    if (f == 2'b01) begin
      v = int'(d);
      s = $sformatf("%0d", v);
    end else if (f == 2'b10) begin
      v = int'($signed(d));
      s = $sformatf("%0d", v);
    end else begin
      for (int i = 3; i >= 0; i--) s = $sformatf("%s%c", s, hexd[(d >> (4 * i)) & 16'hF]);
    end
    return s;
  endfunction

  task automatic start_line(input logic [17:0] e);
    string s;
    int    k;
    bit    dec;
    s = line_text(e[15:0], e[17:16]);
    m_line.delete();
    for (int i = 0; i < s.len(); i++) m_line.push_back(s[i]);
    m_line.push_back(8'h0D);
    m_line.push_back(8'h0A);
    dec = (e[17:16] == 2'b01) || (e[17:16] == 2'b10);
    k = (s[0] == 8'h2D) ? s.len() - 1 : s.len();
    m_wait = 1 + (dec ? k * DATA_W : 0);
    m_active = 1;
  endtask

  // Model advance at each clock edge, plus transfer logging.
  initial begin
    int  sz;
    bit  do_push;
    bit  do_pop;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_fifo.delete();
        m_line.delete();
        m_active = 0;
        m_wait = 0;
        stall_prev = 0;
      end else begin
        if (uout_valid && uin_ready) rx_q.push_back(uart_out);
        stall_prev = uout_valid && !uin_ready;
        stall_byte = uart_out;
        sz = m_fifo.size();
        do_push = res_valid && (sz < DEPTH);
        do_pop  = !m_active && (sz > 0);
        if (m_active) begin
          if (m_wait > 0) m_wait--;
          else if (uin_ready) begin
            void'(m_line.pop_front());
            if (m_line.size() == 0) m_active = 0;
          end
        end else if (do_pop) begin
          start_line(m_fifo.pop_front());
        end
        if (do_push) m_fifo.push_back({res_fmt, res_data});
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    bit m_valid;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_valid = m_active && (m_wait == 0);
        check("res_ready", {7'h0, res_ready}, {7'h0, m_fifo.size() < DEPTH});
        check("overflow", {7'h0, overflow}, {7'h0, res_valid && (m_fifo.size() >= DEPTH)});
        check("busy", {7'h0, busy}, {7'h0, m_active || (m_fifo.size() > 0)});
        check("uout_valid", {7'h0, uout_valid}, {7'h0, m_valid});
        if (m_valid) check("uart_out", uart_out, m_line[0]);
        if (stall_prev) begin
          check("stall_valid", {7'h0, uout_valid}, 8'h01);
          check("stall_byte", uart_out, stall_byte);
        end
      end
    end
  end

  // Random backpressure source used during the stall case.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) uin_ready = ($urandom_range(0, 99) < 30);
    end
  end

  task automatic push(input logic [15:0] d, input logic [1:0] f, output bit ovf);
    res_valid = 1'b1;
    res_data  = d;
    res_fmt   = f;
    @(negedge clk);
    ovf = overflow;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  // Compare logged bytes with a literal; '~' stands for CR, '|' for LF.
  task automatic check_rx(input string name, input string exp);
    string got;
    got = "";
    foreach (rx_q[i]) begin
      if (rx_q[i] == 8'h0D)      got = {got, "~"};
      else if (rx_q[i] == 8'h0A) got = {got, "|"};
      else                       got = $sformatf("%s%c", got, rx_q[i]);
    end
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
    end else begin
      $display("line %s: \"%s\"", name, got);
    end
    rx_q.delete();
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while ((busy || m_active || m_fifo.size() > 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic first_valid(input int start, output int n);
    n = start;
    forever begin
      @(negedge clk);
      if (uout_valid || n > 1000) break;
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ovf;
    int lat;
    int ovf_cnt;
    bit ovf6;
    int n;

    reset = 1'b1;
    res_valid = 1'b0;
    res_data = '0;
    res_fmt = '0;
    uin_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_res_ready", {7'h0, res_ready}, 8'h01);
    check("rst_overflow", {7'h0, overflow}, 8'h00);
    check("rst_uout_valid", {7'h0, uout_valid}, 8'h00);
    check("rst_uart_out", uart_out, 8'h00);
    check("rst_busy", {7'h0, busy}, 8'h00);
    @(posedge clk);
    #1;

    // Hex line and its latency
    push(16'h00A5, 2'b00, ovf);
    first_valid(0, lat);
    check("lat_hex", lat[7:0], 8'd2);
    wait_idle("hex_idle", 200);
    check_rx("hex_00A5", "00A5~|");

    // Unsigned decimal, including zero
    push(16'd12345, 2'b01, ovf);
    push(16'd0, 2'b01, ovf);
    first_valid(1, lat);
    check("lat_dec5", lat[7:0], 8'd82);
    wait_idle("udec_idle", 500);
    check_rx("udec", "12345~|0~|");

    // Signed vs unsigned on boundary values
    push(16'hFFFF, 2'b10, ovf);
    push(16'h8000, 2'b10, ovf);
    push(16'hFFFF, 2'b01, ovf);
    push(16'h8000, 2'b01, ovf);
    wait_idle("sdec_idle", 1000);
    check_rx("sdec_udec", "-1~|-32768~|65535~|32768~|");

    // Backpressure at ~30% ready
    rnd_ready = 1'b1;
    push(16'hABCD, 2'b00, ovf);
    wait_idle("bp_idle", 1000);
    rnd_ready = 1'b0;
    uin_ready = 1'b1;
    check_rx("backpressure", "ABCD~|");

    // FIFO fill with UART stalled
    uin_ready = 1'b0;
    ovf_cnt = 0;
    ovf6 = 0;
    for (int i = 1; i <= 6; i++) begin
      push(16'(i), 2'b00, ovf);
      if (ovf) ovf_cnt++;
      if (i == 6) ovf6 = ovf;
    end
    check("ovf_count", 8'(ovf_cnt), 8'd1);
    check("ovf_on_push6", {7'h0, ovf6}, 8'h01);
    @(negedge clk);
    check("full_res_ready", {7'h0, res_ready}, 8'h00);
    @(posedge clk);
    #1;
    uin_ready = 1'b1;
    wait_idle("fill_idle", 500);
    check_rx("fill_order", "0001~|0002~|0003~|0004~|0005~|");

    // Reset in the middle of a line
    push(16'd12345, 2'b01, ovf);
    n = 0;
    while (rx_q.size() < 2 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL midline_wait: got %0d bytes, expected 2", rx_q.size());
    end
    reset = 1'b1;
    uin_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {7'h0, uout_valid}, 8'h00);
    check("mid_rst_busy", {7'h0, busy}, 8'h00);
    uin_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_rx("mid_rst_residual", "12");
    push(16'h00A5, 2'b00, ovf);
    wait_idle("post_rst_idle", 200);
    check_rx("post_rst", "00A5~|");

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      res_valid = ($urandom_range(0, 3) == 0);
      res_data  = 16'($urandom);
      res_fmt   = 2'($urandom_range(0, 3));
      uin_ready = ($urandom_range(0, 99) < 70);
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    uin_ready = 1'b1;
    wait_idle("random_idle", 3000);
    $display("random phase: %0d bytes transferred", rx_q.size());
    rx_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
